// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch
//  Purpose  : Instruction fetch stage. Issues one bus transaction at a time
//             for the current PC, discards responses made stale by a
//             redirect, and queues fetched instructions (or address-error
//             entries for misaligned PCs) in a 2-entry buffer toward decode.
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch #(
  parameter int BUF_DEPTH = 2  // only 2 is supported
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        pc_adv,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [1:0] CNT_FULL = BUF_DEPTH[1:0];

  typedef struct packed {
    logic        adel;
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        cancel_q, cancel_d;
  logic        req_q, req_d;
  logic [1:0]  cnt_q, cnt_d;
  entry_t      ent_q [BUF_DEPTH];
  entry_t      ent_d [BUF_DEPTH];

  logic        can_issue;
  logic        push;
  logic        pop;
  entry_t      push_ent;

  // A new fetch decision is only taken with room in the buffer and no
  // redirect this cycle, so a push can never land on a full buffer.
  assign can_issue = !flush && (cnt_q < CNT_FULL);
  assign pop       = (cnt_q != 2'd0) && id_ready && !flush;

  // Fetch sequencing: next state, address latch, cancel tracking, pc_adv
  // pulse and the entry to push this cycle.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cancel_d = cancel_q;
    pc_adv   = 1'b0;
    push     = 1'b0;
    push_ent = '0;
    case (state_q)
      S_IDLE: begin
        if (can_issue) begin
          if (pc_i[1:0] == 2'b00) begin
            state_d = S_ADDR;
            addr_d  = pc_i;
          end else begin
            // Misaligned PC: report it without touching the bus.
            push     = 1'b1;
            push_ent = '{adel: 1'b1, inst: 32'h0, pc: pc_i};
            pc_adv   = 1'b1;
          end
        end
      end
      S_ADDR: begin
        // The request stays up even on redirect; the reply is dropped later.
        if (flush) cancel_d = 1'b1;
        if (inst_addr_ok) begin
          state_d = S_DATA;
          pc_adv  = !cancel_q && !flush;
        end
      end
      S_DATA: begin
        if (flush) cancel_d = 1'b1;
        if (inst_data_ok) begin
          state_d  = S_IDLE;
          cancel_d = 1'b0;
          if (!cancel_q && !flush) begin
            push     = 1'b1;
            push_ent = '{adel: 1'b0, inst: inst_rdata, pc: addr_q};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_ADDR);
  end

  // Output buffer: head at entry 0, shifts forward on pop; a redirect
  // empties it and suppresses both push and pop.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < BUF_DEPTH; i++) ent_d[i] = ent_q[i];
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          ent_d[cnt_q[0]] = push_ent;
          cnt_d           = cnt_q + 2'd1;
        end
        2'b01: begin
          ent_d[0] = ent_q[1];
          cnt_d    = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent_d[0] = push_ent;
          end else begin
            ent_d[0] = ent_q[1];
            ent_d[1] = push_ent;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0;
      cancel_q <= 1'b0;
      req_q    <= 1'b0;
      cnt_q    <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cancel_q <= cancel_d;
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < BUF_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign inst_req  = req_q;
  assign inst_addr = addr_q;
  assign id_valid  = (cnt_q != 2'd0);
  assign id_pc     = ent_q[0].pc;
  assign id_inst   = ent_q[0].inst;
  assign id_adel   = ent_q[0].adel;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch
//  Purpose  : Self-checking bench for inst_fetch: directed scenarios followed
//             by randomized bus/decode/redirect traffic against a
//             transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_adv;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  inst_fetch #(.BUF_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .pc_adv       (pc_adv),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_adel      (id_adel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of buffered entries plus the one transaction
  // in flight (0 none, 1 waiting for address accept, 2 waiting for data).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ent_t;

  ent_t        mq[$];
  int          txn;
  logic [31:0] txn_addr;
  bit          doomed;
  logic [31:0] pc_nxt;
  int          dut_pulses;
  int          delay;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    chk("inst_req", {31'h0, inst_req}, {31'h0, txn == 1});
    if (txn == 1) chk("inst_addr", inst_addr, txn_addr);
    chk("id_valid", {31'h0, id_valid}, {31'h0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("id_pc",   id_pc,   mq[0].pc);
      chk("id_inst", id_inst, mq[0].inst);
      chk("id_adel", {31'h0, id_adel}, {31'h0, mq[0].adel});
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check pc_adv, advance
  // the model and the PC register, then check registered outputs.
  task automatic step(input bit fl, input logic [31:0] tgt, input bit rdy,
                      input bit aok, input bit dok, input logic [31:0] rd);
    bit   issue;
    bit   exp_adv;
    bit   do_push;
    ent_t e;
    flush        = fl;
    id_ready     = rdy;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rd;
    #1;
    issue   = (txn == 0) && !fl && (mq.size() < 2);
    exp_adv = (issue && (pc_i[1:0] != 2'b00)) || (txn == 1 && aok && !doomed && !fl);
    chk("pc_adv", {31'h0, pc_adv}, {31'h0, exp_adv});
    if (pc_adv === 1'b1) dut_pulses++;
    do_push = 1'b0;
    e       = '0;
    case (txn)
      0: if (issue) begin
        if (pc_i[1:0] == 2'b00) begin
          txn      = 1;
          txn_addr = pc_i;
        end else begin
          do_push = 1'b1;
          e       = '{pc: pc_i, inst: 32'h0, adel: 1'b1};
        end
      end
      1: begin
        if (fl)  doomed = 1'b1;
        if (aok) txn = 2;
      end
      default: begin
        if (dok) begin
          if (!doomed && !fl) begin
            do_push = 1'b1;
            e       = '{pc: txn_addr, inst: rd, adel: 1'b0};
          end
          txn    = 0;
          doomed = 1'b0;
        end else if (fl) begin
          doomed = 1'b1;
        end
      end
    endcase
    if (fl) begin
      mq.delete();
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    if (fl)           pc_nxt = tgt;
    else if (exp_adv) pc_nxt = pc_i + 32'd4;
    else              pc_nxt = pc_i;
    @(negedge clk);
    pc_i = pc_nxt;
    check_regs();
  endtask

  // Bus that accepts and answers immediately.
  task automatic bstep(input bit rdy);
    step(1'b0, 32'h0, rdy, txn == 1, txn == 2, mem_word(txn_addr));
  endtask

  task automatic model_reset();
    mq.delete();
    txn      = 0;
    txn_addr = 32'h0;
    doomed   = 1'b0;
    delay    = 0;
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    rst          = 1'b1;
    flush        = 1'b0;
    id_ready     = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    pc_i         = pc0;
    model_reset();
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    dut_pulses = 0;
  endtask

  initial begin
    bit          fl;
    bit          rdy;
    bit          aok;
    bit          dok;
    logic [31:0] tgt;
    logic [31:0] rd;

    // Reset state and a single fetch.
    do_reset(32'hBFC0_0000);
    chk("rst_inst_req",  {31'h0, inst_req}, 32'h0);
    chk("rst_inst_addr", inst_addr, 32'h0);
    chk("rst_id_valid",  {31'h0, id_valid}, 32'h0);
    chk("rst_id_pc",     id_pc, 32'h0);
    chk("rst_id_inst",   id_inst, 32'h0);
    chk("rst_id_adel",   {31'h0, id_adel}, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h3C08_0000);
    chk("first_valid", {31'h0, id_valid}, 32'h1);
    chk("first_pc",    id_pc, 32'hBFC0_0000);
    chk("first_inst",  id_inst, 32'h3C08_0000);
    chk("first_adv",   dut_pulses, 32'd1);

    // Decode stalled: buffer fills with two entries and fetching stops.
    repeat (12) bstep(1'b0);
    chk("full_noreq", {31'h0, inst_req}, 32'h0);
    chk("full_head",  id_pc, 32'hBFC0_0000);
    chk("full_adv",   dut_pulses, 32'd2);
    bstep(1'b1);
    chk("drain1_pc", id_pc, 32'hBFC0_0004);
    bstep(1'b1);
    chk("drain2_valid", {31'h0, id_valid}, 32'h0);

    // Redirect while the address phase is pending.
    do_reset(32'hBFC0_0010);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h8000_0180, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    dut_pulses = 0;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("cancel_adv",   dut_pulses, 32'd0);
    chk("cancel_valid", {31'h0, id_valid}, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_req",  {31'h0, inst_req}, 32'h1);
    chk("redir_addr", inst_addr, 32'h8000_0180);

    // Redirect coinciding with the data return.
    do_reset(32'hBFC0_0000);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    chk("flushdata_valid", {31'h0, id_valid}, 32'h0);
    chk("flushdata_req",   {31'h0, inst_req}, 32'h0);

    // Misaligned PC produces an address-error entry without bus traffic.
    do_reset(32'hBFC0_0002);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("adel_valid", {31'h0, id_valid}, 32'h1);
    chk("adel_flag",  {31'h0, id_adel}, 32'h1);
    chk("adel_inst",  id_inst, 32'h0);
    chk("adel_pc",    id_pc, 32'hBFC0_0002);
    chk("adel_req",   {31'h0, inst_req}, 32'h0);
    chk("adel_adv",   dut_pulses, 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset in the data phase, then a stray response.
    do_reset(32'hBFC0_0000);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_req", {31'h0, inst_req}, 32'h0);
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
    chk("stray_valid", {31'h0, id_valid}, 32'h0);
    chk("stray_req",   {31'h0, inst_req}, 32'h1);

    // Randomized traffic.
    do_reset(32'h8000_0000);
    for (int i = 0; i < 3000; i++) begin
      fl  = ($urandom_range(0, 19) == 0);
      tgt = 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      rdy = ($urandom_range(0, 1) == 1);
      aok = (txn == 1) && ($urandom_range(0, 2) != 0);
      dok = (txn == 2) && (delay == 0);
      rd  = dok ? mem_word(txn_addr) : $urandom();
      if (aok)                           delay = $urandom_range(0, 3);
      else if (txn == 2 && delay > 0)    delay = delay - 1;
      step(fl, tgt, rdy, aok, dok, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
